// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite row unpacker.
// Pixel format: 4-bit palette indices packed 32 per 128-bit word.
package sprite_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        EMIT,
        DONE
    } state_t;

    localparam int PIX_PER_WORD = 32;
    localparam int BPP = 4;
    localparam int WORD_W = PIX_PER_WORD * BPP;
    localparam logic [BPP-1:0] TRANSPARENT_IDX = 4'h0;

    function automatic logic is_opaque(input logic [BPP-1:0] p);
        return p != TRANSPARENT_IDX;
    endfunction

endpackage

// File: rtl/nibble_shifter.sv
// 128-bit load/shift register feeding one palette index per cycle.
// Low nibble leaves first; the counter tracks the pixel within the word.
module nibble_shifter
    import sprite_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    output logic [BPP-1:0]    cur_pix,
    output logic [4:0]        pix_idx,
    output logic              last_pix
);

    logic [WORD_W-1:0] shreg;
    logic [4:0]        cnt;

    // Load a fresh word or step one nibble towards the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= din;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= shreg >> BPP;
            cnt   <= cnt + 5'd1;
        end
    end

    assign cur_pix  = shreg[BPP-1:0];
    assign pix_idx  = cnt;
    assign last_pix = (cnt == 5'(PIX_PER_WORD - 1));

endmodule

// File: rtl/sprite_row_unpacker.sv
// Reads one sprite row from on-chip RAM and writes its opaque,
// on-screen pixels into the scanline buffer, one per cycle.
module sprite_row_unpacker
    import sprite_pkg::*;
#(
    parameter int               MEM_AW        = 9,
    parameter int               WORDS_PER_ROW = 2,
    parameter int               LINE_W        = 640,
    parameter logic [MEM_AW-1:0] BASE_ADDR    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_init_done,
    input  logic              start,
    input  logic [5:0]        sprite_y,
    input  logic [9:0]        dest_x,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [127:0]      mem_q,
    output logic              pix_we,
    output logic [9:0]        pix_addr,
    output logic [3:0]        pix_data,
    output logic              busy,
    output logic              done
);

    localparam int WW = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

    state_t          state;
    state_t          state_nx;
    logic [WW-1:0]   w;
    logic [9:0]      x0;
    logic [10:0]     x;
    logic            accept;
    logic            last_word;
    logic            load;
    logic            shift;
    logic            last_pix;
    logic            in_emit;
    logic [3:0]      cur_pix;
    logic [4:0]      pix_idx;

    assign accept    = (state == IDLE) && start && mem_init_done;
    assign last_word = (w == WW'(WORDS_PER_ROW - 1));
    assign in_emit   = (state == EMIT);

    // State register; reset abandons any row in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode plus the per-state control strobes.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                state_nx = LATCH;
            end
            LATCH: begin
                busy     = 1'b1;
                load     = 1'b1;
                state_nx = EMIT;
            end
            EMIT: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (last_pix) begin
                    state_nx = last_word ? DONE : FETCH;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Row origin, word counter and RAM address bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd_addr <= '0;
            w           <= '0;
            x0          <= '0;
        end else if (accept) begin
            x0          <= dest_x;
            w           <= '0;
            mem_rd_addr <= BASE_ADDR
                         + MEM_AW'(sprite_y) * MEM_AW'(WORDS_PER_ROW);
        end else if (in_emit && last_pix && !last_word) begin
            w           <= w + WW'(1);
            mem_rd_addr <= mem_rd_addr + MEM_AW'(1);
        end
    end

    nibble_shifter u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .din      (mem_q),
        .cur_pix  (cur_pix),
        .pix_idx  (pix_idx),
        .last_pix (last_pix)
    );

    // Screen x kept 11 bits wide so far-right rows clip, not wrap.
    assign x = {1'b0, x0} + (11'(w) << 5) + {6'b0, pix_idx};

    assign pix_data = in_emit ? cur_pix : 4'h0;
    assign pix_addr = in_emit ? x[9:0] : 10'h0;
    assign pix_we   = in_emit && is_opaque(cur_pix)
                    && (x < 11'(LINE_W));

endmodule

// File: tb/tb_sprite_row_unpacker.sv
// Directed bench for sprite_row_unpacker with a behavioural
// one-cycle-latency RAM and a negedge write monitor.
module tb_sprite_row_unpacker;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_init_done;
    logic         start;
    logic [5:0]   sprite_y;
    logic [9:0]   dest_x;
    logic [8:0]   mem_rd_addr;
    logic [127:0] mem_q;
    logic         pix_we;
    logic [9:0]   pix_addr;
    logic [3:0]   pix_data;
    logic         busy;
    logic         done;

    logic [127:0] ram [0:511];

    int nvec = 0;
    int nerr = 0;
    int ncyc = 0;
    int t0 = 0;
    int nwr, ndone, nbusy, done_cyc, first_wr, a1, a2, ndist;
    int wr [0:1023];
    bit seen [0:511];

    sprite_row_unpacker dut (
        .clk           (clk),
        .reset         (reset),
        .mem_init_done (mem_init_done),
        .start         (start),
        .sprite_y      (sprite_y),
        .dest_x        (dest_x),
        .mem_rd_addr   (mem_rd_addr),
        .mem_q         (mem_q),
        .pix_we        (pix_we),
        .pix_addr      (pix_addr),
        .pix_data      (pix_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ncyc  <= ncyc + 1;
        mem_q <= ram[mem_rd_addr];
    end

    // Monitor: capture writes, done timing and addresses per row.
    always @(negedge clk) begin
        if (!reset) begin
            if (pix_we) begin
                nwr++;
                wr[pix_addr] = int'(pix_data);
                if (first_wr < 0) first_wr = ncyc - t0;
            end
            if (done) begin
                ndone++;
                done_cyc = ncyc - t0;
            end
            if (busy) begin
                nbusy++;
                if (!seen[mem_rd_addr]) begin
                    seen[mem_rd_addr] = 1'b1;
                    ndist++;
                end
            end
            if (ncyc - t0 == 1)  a1 = int'(mem_rd_addr);
            if (ncyc - t0 == 35) a2 = int'(mem_rd_addr);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_stats();
        nwr = 0; ndone = 0; nbusy = 0; ndist = 0;
        done_cyc = -1; first_wr = -1; a1 = -1; a2 = -1;
        for (int i = 0; i < 1024; i++) wr[i] = -1;
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
    endtask

    task automatic launch(input int y, input int dx);
        clear_stats();
        sprite_y = 6'(y);
        dest_x   = 10'(dx);
        start    = 1'b1;
        t0       = ncyc;
        tick();
        start    = 1'b0;
    endtask

    // Run a row to completion with optional stray starts / init drop.
    task automatic run_row(input string tag, input int y, input int dx,
                           input int p1, input int p2, input int drop_at);
        int c;
        launch(y, dx);
        for (int k = 0; k < 300 && ndone == 0; k++) begin
            c = ncyc - t0;
            start = (c == p1 || c == p2);
            if (c == drop_at) mem_init_done = 1'b0;
            tick();
        end
        start = 1'b0;
        check({tag, "_finished"}, ndone, 1);
        tick();
        tick();
        mem_init_done = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = '0;
        ram[0] = {32{4'h5}};
        ram[1] = {32{4'h5}};
        ram[6] = {2{64'hFEDCBA9876543210}};
        ram[7] = {32{4'h1}};

        reset = 1'b1;
        mem_init_done = 1'b0;
        start = 1'b0;
        sprite_y = '0;
        dest_x = '0;
        clear_stats();
        tick();
        tick();
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(pix_we), 0);
        check("rst_addr", int'(mem_rd_addr), 0);
        check("rst_paddr", int'(pix_addr), 0);
        check("rst_pdata", int'(pix_data), 0);
        reset = 1'b0;
        tick();

        // start before RAM is loaded is dropped
        launch(3, 100);
        repeat (100) tick();
        check("noinit_busy", nbusy, 0);
        check("noinit_wr", nwr, 0);
        check("noinit_done", ndone, 0);

        // plain row
        mem_init_done = 1'b1;
        run_row("row", 3, 100, -1, -1, -1);
        check("row_done_cyc", done_cyc, 69);
        check("row_addr0", a1, 6);
        check("row_addr1", a2, 7);
        check("row_nwr", nwr, 62);
        check("row_first", first_wr, 4);
        check("row_busy", nbusy, 68);
        check("row_px100", wr[100], -1);
        check("row_px101", wr[101], 1);
        check("row_px115", wr[115], 15);
        check("row_px116", wr[116], -1);
        check("row_px117", wr[117], 1);
        check("row_px131", wr[131], 15);
        check("row_px132", wr[132], 1);
        check("row_px163", wr[163], 1);
        check("row_px164", wr[164], -1);

        // fully transparent row
        run_row("transp", 5, 200, -1, -1, -1);
        check("transp_nwr", nwr, 0);
        check("transp_done", done_cyc, 69);

        // right-edge clipping, init dropping mid-row
        run_row("clip", 0, 620, -1, -1, 30);
        check("clip_nwr", nwr, 20);
        check("clip_px619", wr[619], -1);
        check("clip_px620", wr[620], 5);
        check("clip_px639", wr[639], 5);
        check("clip_done", done_cyc, 69);

        // x beyond 1023 must not alias to low addresses
        run_row("alias", 0, 1020, -1, -1, -1);
        check("alias_nwr", nwr, 0);

        // starts while busy are ignored
        run_row("coll", 3, 100, 10, 40, -1);
        repeat (80) tick();
        check("coll_ndone", ndone, 1);
        check("coll_ndist", ndist, 2);
        check("coll_nwr", nwr, 62);

        // reset mid-row
        launch(3, 100);
        while (ncyc - t0 < 20) tick();
        check("prerst_we", int'(pix_we), 1);
        reset = 1'b1;
        #1;
        check("rst_mid_we", int'(pix_we), 0);
        check("rst_mid_busy", int'(busy), 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (80) tick();
        check("rst_mid_done", ndone, 0);
        run_row("restart", 3, 100, -1, -1, -1);
        check("restart_addr0", a1, 6);
        check("restart_addr1", a2, 7);
        check("restart_done", done_cyc, 69);
        check("restart_nwr", nwr, 62);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
